// File: rtl/bcd_decoder_pkg.sv
// Shared definitions for the microwave timer display decoder.
// Segment vector layout: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
// All constants are active-high (1 = segment lit). Inversion for common-anode
// displays is applied by the decoder instances, not here.
package bcd_decoder_pkg;

  typedef logic [6:0] seg_t;

  localparam int unsigned NUM_DIGITS = 3;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_BLANK = 7'h00;

  // Active-high decode of one BCD digit; codes 10-15 blank the digit.
  function automatic seg_t bcd_to_seg(input logic [3:0] digit);
    seg_t segs;
    segs = SEG_BLANK;
    case (digit)
      4'd0:    segs = SEG_0;
      4'd1:    segs = SEG_1;
      4'd2:    segs = SEG_2;
      4'd3:    segs = SEG_3;
      4'd4:    segs = SEG_4;
      4'd5:    segs = SEG_5;
      4'd6:    segs = SEG_6;
      4'd7:    segs = SEG_7;
      4'd8:    segs = SEG_8;
      4'd9:    segs = SEG_9;
      default: segs = SEG_BLANK;
    endcase
    return segs;
  endfunction

  // Apply display polarity to an active-high pattern.
  function automatic seg_t seg_polarity(input seg_t segs, input logic active_low);
    return active_low ? ~segs : segs;
  endfunction

endpackage

// File: rtl/bcd_decoder_digit.sv
// bcd_digit_to_seg: combinational single-digit BCD to 7-segment decoder.
// Ports:
//   digit_i  [3:0]  BCD digit (10-15 decode to blank)
//   segs_o   [6:0]  segment pattern, polarity selected by SEG_ACTIVE_LOW
module bcd_digit_to_seg
  import bcd_decoder_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] digit_i,
  output logic [6:0] segs_o
);

  always_comb begin
    segs_o = seg_polarity(bcd_to_seg(digit_i), SEG_ACTIVE_LOW);
  end

endmodule

// File: rtl/bcd_decoder.sv
// bcd_decoder: decodes the minutes, seconds-tens and seconds-ones BCD digits of
// the oven timer into three registered 7-segment patterns (latency 1 clock).
// Ports:
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset; blanks all outputs at once
//   min            minutes digit (BCD)
//   sec_tens       seconds-tens digit (BCD)
//   sec_ones       seconds-ones digit (BCD)
//   min_segs       segment pattern for min
//   sec_tens_segs  segment pattern for sec_tens
//   sec_ones_segs  segment pattern for sec_ones
// SEG_ACTIVE_LOW=1 inverts every segment bit, including the reset (blank) value.
module bcd_decoder
  import bcd_decoder_pkg::*;
#(
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] min,
  input  logic [3:0] sec_tens,
  input  logic [3:0] sec_ones,
  output logic [6:0] min_segs,
  output logic [6:0] sec_tens_segs,
  output logic [6:0] sec_ones_segs
);

  // Blank in the selected display polarity.
  localparam seg_t BLANK_OUT = {7{SEG_ACTIVE_LOW}} ^ SEG_BLANK;

  logic [3:0] digit   [NUM_DIGITS];
  seg_t       segs_d  [NUM_DIGITS];
  seg_t       segs_q  [NUM_DIGITS];

  assign digit[0] = min;
  assign digit[1] = sec_tens;
  assign digit[2] = sec_ones;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      bcd_digit_to_seg #(
        .SEG_ACTIVE_LOW (SEG_ACTIVE_LOW)
      ) u_dec (
        .digit_i (digit[gi]),
        .segs_o  (segs_d[gi])
      );

      // Registered outputs keep the display pins glitch-free between edges.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          segs_q[gi] <= BLANK_OUT;
        end else begin
          segs_q[gi] <= segs_d[gi];
        end
      end
    end
  endgenerate

  assign min_segs      = segs_q[0];
  assign sec_tens_segs = segs_q[1];
  assign sec_ones_segs = segs_q[2];

endmodule

// File: tb/tb_bcd_decoder.sv
// Self-checking bench for bcd_decoder: one active-high and one inverted
// instance share the same stimulus and are compared against a table model.
module tb_bcd_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] min;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic [6:0] min_segs, sec_tens_segs, sec_ones_segs;
  logic [6:0] inv_min_segs, inv_sec_tens_segs, inv_sec_ones_segs;

  int n_checks;
  int n_fails;

  bcd_decoder #(.SEG_ACTIVE_LOW(1'b0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .min           (min),
    .sec_tens      (sec_tens),
    .sec_ones      (sec_ones),
    .min_segs      (min_segs),
    .sec_tens_segs (sec_tens_segs),
    .sec_ones_segs (sec_ones_segs)
  );

  bcd_decoder #(.SEG_ACTIVE_LOW(1'b1)) dut_inv (
    .clk           (clk),
    .rst_n         (rst_n),
    .min           (min),
    .sec_tens      (sec_tens),
    .sec_ones      (sec_ones),
    .min_segs      (inv_min_segs),
    .sec_tens_segs (inv_sec_tens_segs),
    .sec_ones_segs (inv_sec_ones_segs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the display's decode table, indexed by digit value.
  function automatic logic [6:0] model_seg(input int d);
    logic [6:0] tbl [10];
    tbl = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    if (d >= 0 && d <= 9) return tbl[d];
    return 7'h00;
  endfunction

  task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare all six outputs against the model for the given digits.
  task automatic check_all(input string tag, input int m, input int t, input int o);
    check({tag, ".min"},      min_segs,          model_seg(m));
    check({tag, ".tens"},     sec_tens_segs,     model_seg(t));
    check({tag, ".ones"},     sec_ones_segs,     model_seg(o));
    check({tag, ".inv_min"},  inv_min_segs,      ~model_seg(m));
    check({tag, ".inv_tens"}, inv_sec_tens_segs, ~model_seg(t));
    check({tag, ".inv_ones"}, inv_sec_ones_segs, ~model_seg(o));
    $display("txn %-10s in=(%0d,%0d,%0d) out=%h,%h,%h inv=%h,%h,%h", tag, m, t, o,
             min_segs, sec_tens_segs, sec_ones_segs,
             inv_min_segs, inv_sec_tens_segs, inv_sec_ones_segs);
  endtask

  task automatic check_blank(input string tag);
    check({tag, ".min"},      min_segs,          7'h00);
    check({tag, ".tens"},     sec_tens_segs,     7'h00);
    check({tag, ".ones"},     sec_ones_segs,     7'h00);
    check({tag, ".inv_min"},  inv_min_segs,      7'h7F);
    check({tag, ".inv_tens"}, inv_sec_tens_segs, 7'h7F);
    check({tag, ".inv_ones"}, inv_sec_ones_segs, 7'h7F);
    $display("txn %-10s blank out=%h,%h,%h inv=%h,%h,%h", tag,
             min_segs, sec_tens_segs, sec_ones_segs,
             inv_min_segs, inv_sec_tens_segs, inv_sec_ones_segs);
  endtask

  // Drive digits between edges, then check one edge later.
  task automatic step(input string tag, input int m, input int t, input int o);
    min      = 4'(m);
    sec_tens = 4'(t);
    sec_ones = 4'(o);
    @(posedge clk);
    #1;
    check_all(tag, m, t, o);
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n    = 1'b1;
    min      = 4'd3;
    sec_tens = 4'd4;
    sec_ones = 4'd5;

    // Asynchronous reset before any clock edge.
    #1 rst_n = 1'b0;
    #1 check_blank("rst_async");
    // Held blank across edges while in reset.
    repeat (2) @(posedge clk);
    #1 check_blank("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_blank("rst_rel");
    @(posedge clk);
    #1 check_all("rst_load", 3, 4, 5);
    @(negedge clk);

    // Sweep of consecutive digit triples.
    for (int i = 0; i < 10; i++) begin
      step("sweep", i, (i + 1) % 10, (i + 2) % 10);
    end
    step("ex890", 8, 9, 0);

    // Invalid codes blank, then recover.
    step("invalid", 15, 10, 13);
    step("invalid2", 11, 12, 14);
    step("nines", 9, 9, 9);
    step("inv0_12", 0, 12, 0);

    // Latency: change mid-cycle, output holds until next edge.
    step("lat_pre", 2, 5, 7);
    sec_ones = 4'd1;
    #2 check("lat_hold", sec_ones_segs, 7'h70);
    @(posedge clk);
    #1 check("lat_upd", sec_ones_segs, 7'h30);
    check("lat_inv", inv_sec_ones_segs, ~7'h30);
    @(negedge clk);

    // Mid-operation reset between edges.
    step("pre_rst", 8, 8, 8);
    #2 rst_n = 1'b0;
    #1 check_blank("mid_rst");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_blank("mid_hold");
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1 check_all("mid_load", 8, 8, 8);
    @(negedge clk);

    // Randomized steps, biased mostly toward valid digits.
    for (int r = 0; r < 40; r++) begin
      int m, t, o;
      m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      t = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      o = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9));
      step("rand", m, t, o);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
